axi_lite_reg_slave: RTL and testbench

- AXI4-Lite slave register bank. It is the block whose handshakes the team's interface assertion checker monitors on the same interface.
- Directly downstream of the bench/master driver: it consumes the AW/W/AR channels and produces the B/R channels.
- Holds NUM_REGS 32-bit software registers.
- Every valid it raises must stay high until the matching ready, so the checker's valid-stability assertions pass by construction.

---
 rtl/axi_lite_reg_slave_pkg.sv | 45 ++++
 rtl/axi_lite_reg_slave_if.sv | 45 ++++
 rtl/axi_lite_reg_bank.sv | 64 ++++++
 rtl/axi_lite_reg_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_reg_slave_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_pkg
//   Shared types and helpers for the AXI4-Lite register slave.
//   - resp_t      : AXI response codes used on B and R channels
//   - wr_state_t  : write-path handshake FSM states
//   - rd_state_t  : read-path handshake FSM states
//   - strb_merge  : byte-lane merge of new write data into an old word
// ----------------------------------------------------------------------------
package axi_lite_pkg;

  // The register bank only supports 32-bit words (4 byte lanes).
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'b00,
    W_COMMIT = 2'b01,
    W_RESP   = 2'b10
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Lanes with strb[i]=1 take the new byte, all other lanes keep the old byte.
  function automatic logic [AXI_DATA_W-1:0] strb_merge(
    input logic [AXI_DATA_W-1:0] old_data,
    input logic [AXI_DATA_W-1:0] new_data,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] merged;
    merged = old_data;
    for (int i = 0; i < AXI_STRB_W; i++) begin
      merged[8*i +: 8] = strb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave_if
//   AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   modport master : drives AW/W/AR payload+valid and B/R ready
//   modport slave  : drives AW/W/AR ready and B/R payload+valid
// ----------------------------------------------------------------------------
interface axi_lite_reg_slave_if import axi_lite_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  // Write address channel
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  // Write response channel
  resp_t               bresp;
  logic                bvalid;
  logic                bready;
  // Read address channel
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  // Read data channel
  logic [DATA_W-1:0]   rdata;
  resp_t               rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_reg_bank.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_bank
//   NUM_REGS x 32-bit register storage, asynchronously reset to zero.
//   Ports:
//     clk, rst                 : clock, async active-high reset
//     wr_en_i/wr_idx_i/...     : one byte-enabled write port (applied at clk edge)
//     rd_en_i/rd_idx_i         : read request; word captured at clk edge
//     rd_data_o                : registered read data (0 for an index with no
//                                register behind it), held until next rd_en_i
// ----------------------------------------------------------------------------
module axi_lite_reg_bank import axi_lite_pkg::*; #(
  parameter int IDX_W    = 6,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [AXI_DATA_W-1:0] wr_data_i,
  input  logic [AXI_STRB_W-1:0] wr_strb_i,
  input  logic                  rd_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [AXI_DATA_W-1:0] rd_data_o
);

  logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];
  logic [AXI_DATA_W-1:0] rd_sel_s;
  logic [AXI_DATA_W-1:0] rd_data_q;

  // Register storage with byte-enabled write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {AXI_DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en_i && (int'(wr_idx_i) == i)) begin
          regs_q[i] <= strb_merge(regs_q[i], wr_data_i, wr_strb_i);
        end
      end
    end
  end

  // Read mux; an index beyond the bank matches nothing and reads as zero.
  always_comb begin
    rd_sel_s = {AXI_DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_sel_s = (int'(rd_idx_i) == i) ? regs_q[i] : rd_sel_s;
    end
  end

  // Read data register; samples the pre-write word if a write lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= {AXI_DATA_W{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= rd_sel_s;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave
//   AXI4-Lite slave exposing NUM_REGS 32-bit software registers.
//   Ports:
//     clk  : single clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : axi_lite_reg_slave_if.slave (AW/W/AR in, B/R out)
//   Write and read FSMs are independent; each allows one outstanding
//   transaction. All bus outputs come straight from flops, and every valid
//   stays asserted until its ready.
// ----------------------------------------------------------------------------
module axi_lite_reg_slave import axi_lite_pkg::*; #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic clk,
  input logic rst,
  axi_lite_reg_slave_if.slave bus
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;

  // Write path state
  wr_state_t         wr_state_q, wr_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  resp_t             bresp_q, bresp_d;

  // Read path state
  rd_state_t         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  resp_t             rresp_q, rresp_d;

  logic              aw_hs_s, w_hs_s, ar_hs_s;
  logic              have_aw_s, have_w_s;
  logic              wr_en_s;
  logic              wr_in_range_s, rd_in_range_s;
  logic [IDX_W-1:0]  ar_idx_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              unused_addr_lsb_s;

  assign aw_hs_s   = bus.awvalid & awready_q;
  assign w_hs_s    = bus.wvalid & wready_q;
  assign ar_hs_s   = bus.arvalid & arready_q;
  assign have_aw_s = aw_hs_s | aw_held_q;
  assign have_w_s  = w_hs_s | w_held_q;

  // Word index from the byte address; the two LSBs never select anything.
  assign ar_idx_s          = bus.araddr[ADDR_W-1:2];
  assign unused_addr_lsb_s = ^{bus.awaddr[1:0], bus.araddr[1:0]};
  assign wr_in_range_s     = (int'(aw_idx_q) < NUM_REGS);
  assign rd_in_range_s     = (int'(ar_idx_s) < NUM_REGS);

  // Write FSM next-state and output logic.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_hs_s ? bus.awaddr[ADDR_W-1:2] : aw_idx_q;
    wdata_d    = w_hs_s ? bus.wdata : wdata_q;
    wstrb_d    = w_hs_s ? bus.wstrb : wstrb_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_en_s    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (have_aw_s && have_w_s) begin
          // Both halves present: stop accepting until the response retires.
          wr_state_d = W_COMMIT;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
        end else begin
          // Hold whichever half arrived and stall only that channel.
          aw_held_d = have_aw_s;
          w_held_d  = have_w_s;
          awready_d = ~have_aw_s;
          wready_d  = ~have_w_s;
        end
      end
      W_COMMIT: begin
        wr_en_s    = wr_in_range_s;
        bresp_d    = wr_in_range_s ? OKAY : SLVERR;
        bvalid_d   = 1'b1;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        awready_d  = 1'b1;
        wready_d   = 1'b1;
        bvalid_d   = 1'b0;
      end
    endcase
  end

  // Write FSM state and registered B-channel / ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= {IDX_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wstrb_q    <= {STRB_W{1'b0}};
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read FSM next-state and output logic.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_d = R_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = rd_in_range_s ? OKAY : SLVERR;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          rd_state_d = R_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        arready_d  = 1'b1;
        rvalid_d   = 1'b0;
      end
    endcase
  end

  // Read FSM state and registered R-channel / ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  axi_lite_reg_bank #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_s),
    .wr_idx_i  (aw_idx_q),
    .wr_data_i (wdata_q),
    .wr_strb_i (wstrb_q),
    .rd_en_i   (ar_hs_s),
    .rd_idx_i  (ar_idx_s),
    .rd_data_o (rd_data_s)
  );

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rd_data_s;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//   Directed, table-driven bench for axi_lite_reg_slave (NUM_REGS=16).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;
  import axi_lite_pkg::*;

  localparam int NV = 14;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_lite_reg_slave_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axi_lite_reg_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write with bready=1; lat = edges from the later handshake to bvalid.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_now, w_now;
    int n = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      tick();
      n++;
      if (aw_now) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_now)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
    end
    lat = 1;
    while (!bus.bvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("write_completes", {29'd0, aw_done, w_done, bus.bvalid}, 32'd7);
    resp = bus.bresp;
    tick();
  endtask

  // Full read with rready=1; lat = edges from the AR handshake to rvalid.
  task automatic do_read(input logic [7:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    bit ar_done = 1'b0;
    bit ar_now;
    int n = 0;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (!ar_done && n < 20) begin
      ar_now = bus.arvalid && bus.arready;
      tick();
      n++;
      if (ar_now) begin ar_done = 1'b1; bus.arvalid = 1'b0; end
    end
    lat = 1;
    while (!bus.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("read_completes", {30'd0, ar_done, bus.rvalid}, 32'd3);
    data = bus.rdata;
    resp = bus.rresp;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    int          lat;

    vecs[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 8'h08, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'hAABBCCDD};
    vecs[4]  = '{1'b1, 8'h3C, 32'h12345678, 4'hF, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'h12345678};
    vecs[6]  = '{1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[8]  = '{1'b0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[9]  = '{1'b1, 8'h04, 32'h00000000, 4'h0, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 8'h05, 32'h0000AB00, 4'h2, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 8'h07, 32'h0,        4'h0, 2'b00, 32'hDEADABEF};
    vecs[13] = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h00000000};

    bus.awaddr = 8'h00; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = 8'h00; bus.arvalid = 1'b0; bus.rready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_awready", {31'd0, bus.awready}, 32'd1);
    check("rst_wready",  {31'd0, bus.wready},  32'd1);
    check("rst_arready", {31'd0, bus.arready}, 32'd1);
    check("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
    check("rst_bresp",   {30'd0, bus.bresp},   32'd0);
    check("rst_rresp",   {30'd0, bus.rresp},   32'd0);
    check("rst_rdata",   bus.rdata,            32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rs, lat);
        check($sformatf("vec%0d_bresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
        check($sformatf("vec%0d_blat", i), lat, 32'd2);
      end else begin
        do_read(vecs[i].addr, rd, rs, lat);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), {30'd0, rs}, {30'd0, vecs[i].exp_resp});
        check($sformatf("vec%0d_rlat", i), lat, 32'd1);
      end
    end

    // AW first, W three cycles later, partial strobe onto reg[2]=0xAABBCCDD
    bus.awaddr = 8'h08; bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("split_awready_c1", {31'd0, bus.awready}, 32'd0);
    check("split_wready_c1",  {31'd0, bus.wready},  32'd1);
    tick();
    check("split_awready_c2", {31'd0, bus.awready}, 32'd0);
    check("split_bvalid_c2",  {31'd0, bus.bvalid},  32'd0);
    tick();
    check("split_awready_c3", {31'd0, bus.awready}, 32'd0);
    check("split_wready_c3",  {31'd0, bus.wready},  32'd1);
    bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("split_bvalid_c4", {31'd0, bus.bvalid}, 32'd0);
    check("split_wready_c4", {31'd0, bus.wready}, 32'd0);
    tick();
    check("split_bvalid_c5", {31'd0, bus.bvalid}, 32'd1);
    check("split_bresp_c5",  {30'd0, bus.bresp},  32'd0);
    tick();
    check("split_bvalid_c6",  {31'd0, bus.bvalid},  32'd0);
    check("split_awready_c6", {31'd0, bus.awready}, 32'd1);
    do_read(8'h08, rd, rs, lat);
    check("split_readback", rd, 32'hAA22CC44);

    // Backpressure on B and R for 5 cycles
    bus.awaddr = 8'h0C; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    bus.araddr = 8'h04; bus.arvalid = 1'b1; bus.rready = 1'b0;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check("bp_rvalid_c1", {31'd0, bus.rvalid}, 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_bvalid_%0d", k),  {31'd0, bus.bvalid},  32'd1);
      check($sformatf("bp_bresp_%0d", k),   {30'd0, bus.bresp},   32'd0);
      check($sformatf("bp_rvalid_%0d", k),  {31'd0, bus.rvalid},  32'd1);
      check($sformatf("bp_rdata_%0d", k),   bus.rdata,            32'hDEADABEF);
      check($sformatf("bp_rresp_%0d", k),   {30'd0, bus.rresp},   32'd0);
      check($sformatf("bp_readies_%0d", k), {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
      tick();
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    check("bp_release_valids",  {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    check("bp_release_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
    tick();
    check("bp_no_duplicate", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    do_read(8'h0C, rd, rs, lat);
    check("bp_readback", rd, 32'hCAFEF00D);

    // Read sampled in the W_COMMIT cycle of a write to the same register
    do_write(8'h04, 32'h00000005, 4'hF, rs, lat);
    check("col_setup_bresp", {30'd0, rs}, 32'd0);
    bus.awaddr = 8'h04; bus.wdata = 32'h00000009; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 8'h04; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("col_rvalid", {31'd0, bus.rvalid}, 32'd1);
    check("col_rdata_old", bus.rdata, 32'h00000005);
    check("col_bvalid", {31'd0, bus.bvalid}, 32'd1);
    tick();
    do_read(8'h04, rd, rs, lat);
    check("col_rdata_new", rd, 32'h00000009);

    // Asynchronous reset while a write response is pending
    bus.awaddr = 8'h10; bus.wdata = 32'h00000077; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    check("mid_rst_pre_bvalid", {31'd0, bus.bvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bvalid",  {31'd0, bus.bvalid}, 32'd0);
    check("mid_rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
    check("mid_rst_rvalid",  {31'd0, bus.rvalid}, 32'd0);
    tick();
    rst = 1'b0;
    bus.bready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      do_read(8'(i * 4), rd, rs, lat);
      check($sformatf("mid_rst_reg%0d", i), rd, 32'd0);
    end
    do_write(8'h10, 32'h55AA55AA, 4'hF, rs, lat);
    check("post_rst_bresp", {30'd0, rs}, 32'd0);
    check("post_rst_blat", lat, 32'd2);
    do_read(8'h10, rd, rs, lat);
    check("post_rst_rdata", rd, 32'h55AA55AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
